uart_fifo_mmio: RTL and testbench
=================================

UART_FIFO_MMIO -- requirements
Module: uart_fifo_mmio

Interface
REQ-001 Parameter DATA_BITS, default 8, serial data bits per frame; legal values 5..8.
REQ-002 Parameter FIFO_DEPTH, default 8, entries in each of the TX and RX FIFOs; power of 2, at least 2.
REQ-003 Parameter DIV_WIDTH, default 16, width of the baud divisor register.
REQ-004 Parameter DEFAULT_DIV, default 867, divisor reset value (115200 baud at a 100 MHz clock).
REQ-005 clock  in  1  single clock domain, rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 we  in  1  register write strobe.
REQ-008 re  in  1  register read strobe; pops the RX FIFO only at the DATA register.
REQ-009 addr  in  2  register select: 0 DATA, 1 STATUS, 2 DIV, 3 CTRL.
REQ-010 wdata  in  32  write data.
REQ-011 rdata  out  32  combinational read data for addr; unused bits read 0.
REQ-012 rx  in  1  serial input, asynchronous, idle high.
REQ-013 tx  out  1  serial output, idle high.
REQ-014 irq  out  1  level interrupt, registered.

Function
REQ-015 The bit period shall be DIV+1 clocks; DIV writes shall take effect at the next frame start on each of TX and RX, never mid-frame.
REQ-016 Frame format: 1 start bit (0), DATA_BITS data bits LSB first, optional parity bit, 1 stop bit (1).
REQ-017 CTRL bits: [0] tx_en, [1] rx_en, [2] par_en, [3] par_odd, [4] irq_rx_en, [5] irq_txe_en; the register is read/write.
REQ-018 STATUS read bits: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_avail, [4] rx_overrun, [5] frame_err, [6] parity_err, [7] tx_overflow.
REQ-019 Writing STATUS shall clear each sticky bit [7:4] whose wdata bit is 1 (write-1-to-clear).
REQ-020 A DATA write shall push wdata[DATA_BITS-1:0] into the TX FIFO; when the FIFO is full, the data shall be dropped and tx_overflow set.
REQ-021 A DATA read shall return the RX FIFO head in rdata[DATA_BITS-1:0] in the same cycle and pop it at that clock edge; an empty FIFO shall return 0 with no pop.
REQ-022 The TX FSM shall use states IDLE -> START -> DATA -> PARITY (only if par_en) -> STOP -> IDLE, each held for exactly DIV+1 clocks.
REQ-023 In IDLE with tx_en=1 and the TX FIFO not empty, the TX FSM shall pop one entry and drive start on the next clock; when tx_en is cleared, the current frame shall finish first.
REQ-024 Back-to-back frames shall have no idle gap: the next START shall follow STOP immediately when the FIFO is non-empty.
REQ-025 The parity bit shall be the XOR of the data bits for even parity and the inverted XOR for odd parity (par_odd=1).
REQ-026 rx shall pass through a 2-flop synchroniser before use; all RX timing is relative to the synchronised signal.
REQ-027 The RX FSM shall use states IDLE -> START -> DATA -> PARITY (if par_en) -> STOP -> IDLE; it shall leave IDLE on a synchronised falling edge while rx_en=1.
REQ-028 START shall resample at (DIV+1)/2 clocks (integer division); if the line is high, it is a false start and the FSM shall return to IDLE with nothing stored.
REQ-029 Data, parity and stop bits shall be sampled every DIV+1 clocks after the mid-start sample.
REQ-030 On a stop bit of 0, frame_err shall be set and the byte discarded; the FSM shall then wait for rx high before returning to IDLE.
REQ-031 On a parity mismatch, parity_err shall be set and the byte discarded.
REQ-032 A good byte arriving while the RX FIFO is full shall be dropped and rx_overrun set; FIFO contents are unchanged.
REQ-033 A push and a pop in the same cycle on the same FIFO shall both take effect; a full FIFO stays full with the oldest entry replaced in order, and this push shall not count as overflow.
REQ-034 FIFO pointers shall wrap modulo FIFO_DEPTH, and full/empty shall be distinguished with an extra pointer bit.
REQ-035 irq shall be (irq_rx_en & rx_avail) | (irq_txe_en & tx_empty & TX FSM idle), registered one cycle after the condition.

Reset
REQ-036 Under reset, both FIFOs shall empty, both FSMs go to IDLE, and all sticky bits clear.
REQ-037 Under reset: tx=1, irq=0, DIV=DEFAULT_DIV, CTRL=0 (TX/RX disabled).
REQ-038 Reset asserted mid-frame shall abort the frame within one clock (tx=1 on the next edge) and drop any partially received byte.

Verification
REQ-039 DIV=3, CTRL=0x01, write DATA 0xA5 -> tx: 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; tx_empty=1 after stop.
REQ-040 CTRL=0x07 (even parity), DIV=3, drive rx frame 0x3C with parity 0 -> rx_avail=1, DATA read=0x3C, rx_avail=0 after the pop.
REQ-041 Same setup, drive 0x3C with parity 1 -> parity_err=1, rx_avail=0; STATUS write 0x40 -> parity_err=0.
REQ-042 FIFO_DEPTH=8, rx_en=1, receive 9 good bytes 0x01..0x09 without reads -> rx_full=1, rx_overrun=1, reads return 0x01..0x08.
REQ-043 A 1-clock low glitch on rx at DIV=7 -> no byte stored, no error flags, FSM back in IDLE.
REQ-044 Assert reset during the DATA bit 3 of a TX frame -> tx=1 next cycle, tx_empty=1, DIV=867, irq=0.

Source files
------------

// File: rtl/uart_fifo_mmio.sv
// uart_fifo_mmio: memory-mapped UART with TX/RX FIFOs, optional parity and a level interrupt.
// Register map: 0 DATA, 1 STATUS, 2 DIV, 3 CTRL. Bit period is DIV+1 clocks.
module uart_fifo_mmio #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 867
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = 1;
    localparam logic [DIV_WIDTH-1:0] CntOne = 1;
    localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWait} rx_state_e;

    // Bus decode
    logic data_wr, status_wr, div_wr, ctrl_wr, data_rd;
    assign data_wr   = we && (addr == 2'd0);
    assign status_wr = we && (addr == 2'd1);
    assign div_wr    = we && (addr == 2'd2);
    assign ctrl_wr   = we && (addr == 2'd3);
    assign data_rd   = re && (addr == 2'd0);

    logic unused_wdata;
    assign unused_wdata = ^wdata;

    // Configuration and sticky status
    logic [DIV_WIDTH-1:0] div_q;
    logic [5:0]           ctrl_q;
    logic rx_overrun_q, frame_err_q, parity_err_q, tx_overflow_q;

    // TX FIFO
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0]          tx_wptr_q, tx_rptr_q;
    logic                 tx_empty, tx_full, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;
    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                      (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
    assign tx_push  = data_wr && (!tx_full || tx_pop);
    assign tx_head  = tx_mem[tx_rptr_q[AW-1:0]];

    // RX FIFO
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]          rx_wptr_q, rx_rptr_q;
    logic                 rx_empty, rx_full, rx_push, rx_pop;
    logic [DATA_BITS-1:0] rx_head;
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                      (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
    assign rx_pop   = data_rd && !rx_empty;
    assign rx_head  = rx_mem[rx_rptr_q[AW-1:0]];

    // TX FSM state
    tx_state_e            tx_state_q, tx_state_d;
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d;

    // RX FSM state
    rx_state_e            rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
    logic                 rx_bad_q, rx_bad_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 set_overrun, set_frame_err, set_parity_err;

    // First START sample lands (DIV+1)/2 clocks after the synchronised falling edge
    logic [DIV_WIDTH:0]   rx_sum, rx_half;
    logic [DIV_WIDTH-1:0] rx_first;
    assign rx_sum   = {1'b0, div_q} + {{DIV_WIDTH{1'b0}}, 1'b1};
    assign rx_half  = rx_sum >> 1;
    assign rx_first = (rx_half == '0) ? '0 :
                      DIV_WIDTH'(rx_half - {{DIV_WIDTH{1'b0}}, 1'b1});

    // TX next-state: load a new frame from the FIFO in IDLE or straight out of STOP
    always_comb begin
        logic tx_load;
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_div_d    = tx_div_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_par_en_d = tx_par_en_q;
        tx_par_d    = tx_par_q;
        tx_pop      = 1'b0;
        tx_load     = 1'b0;
        if (tx_state_q != TxIdle) tx_cnt_d = tx_cnt_q - CntOne;
        unique case (tx_state_q)
            TxIdle: begin
                if (ctrl_q[0] && !tx_empty) tx_load = 1'b1;
            end
            TxStart: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = tx_div_q;
                    tx_bit_d   = 3'd0;
                end
            end
            TxData: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = tx_div_q;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == LastBit) tx_state_d = tx_par_en_q ? TxParity : TxStop;
                end
            end
            TxParity: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TxStop;
                    tx_cnt_d   = tx_div_q;
                end
            end
            TxStop: begin
                if (tx_cnt_q == '0) begin
                    if (ctrl_q[0] && !tx_empty) tx_load = 1'b1;
                    else tx_state_d = TxIdle;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
        // Divisor and parity mode are captured per frame so register writes never act mid-frame
        if (tx_load) begin
            tx_pop      = 1'b1;
            tx_state_d  = TxStart;
            tx_cnt_d    = div_q;
            tx_div_d    = div_q;
            tx_shift_d  = tx_head;
            tx_par_en_d = ctrl_q[2];
            tx_par_d    = (^tx_head) ^ ctrl_q[3];
        end
    end

    // TX line decode from the current state
    always_comb begin
        tx = 1'b1;
        case (tx_state_q)
            TxStart:  tx = 1'b0;
            TxData:   tx = tx_shift_q[0];
            TxParity: tx = tx_par_q;
            default:  tx = 1'b1;
        endcase
    end

    // RX next-state: sample mid-bit, validate parity/stop, push good bytes
    always_comb begin
        rx_state_d     = rx_state_q;
        rx_cnt_d       = rx_cnt_q;
        rx_div_d       = rx_div_q;
        rx_bit_d       = rx_bit_q;
        rx_shift_d     = rx_shift_q;
        rx_par_en_d    = rx_par_en_q;
        rx_par_odd_d   = rx_par_odd_q;
        rx_bad_d       = rx_bad_q;
        rx_push        = 1'b0;
        set_overrun    = 1'b0;
        set_frame_err  = 1'b0;
        set_parity_err = 1'b0;
        if (rx_state_q != RxIdle && rx_state_q != RxWait) rx_cnt_d = rx_cnt_q - CntOne;
        unique case (rx_state_q)
            RxIdle: begin
                if (ctrl_q[1] && rx_prev_q && !rx_sync_q) begin
                    rx_state_d   = RxStart;
                    rx_cnt_d     = rx_first;
                    rx_div_d     = div_q;
                    rx_par_en_d  = ctrl_q[2];
                    rx_par_odd_d = ctrl_q[3];
                end
            end
            RxStart: begin
                if (rx_cnt_q == '0) begin
                    if (rx_sync_q) begin
                        rx_state_d = RxIdle;
                    end else begin
                        rx_state_d = RxData;
                        rx_cnt_d   = rx_div_q;
                        rx_bit_d   = 3'd0;
                        rx_bad_d   = 1'b0;
                    end
                end
            end
            RxData: begin
                if (rx_cnt_q == '0) begin
                    rx_cnt_d   = rx_div_q;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == LastBit) rx_state_d = rx_par_en_q ? RxParity : RxStop;
                end
            end
            RxParity: begin
                if (rx_cnt_q == '0) begin
                    rx_cnt_d   = rx_div_q;
                    rx_state_d = RxStop;
                    if (rx_sync_q != ((^rx_shift_q) ^ rx_par_odd_q)) begin
                        set_parity_err = 1'b1;
                        rx_bad_d       = 1'b1;
                    end
                end
            end
            RxStop: begin
                if (rx_cnt_q == '0) begin
                    if (!rx_sync_q) begin
                        set_frame_err = 1'b1;
                        rx_state_d    = RxWait;
                    end else begin
                        rx_state_d = RxIdle;
                        if (!rx_bad_q) begin
                            if (rx_full && !rx_pop) set_overrun = 1'b1;
                            else rx_push = 1'b1;
                        end
                    end
                end
            end
            RxWait: begin
                if (rx_sync_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // FIFO storage (not reset; validity tracked by pointers)
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= wdata[DATA_BITS-1:0];
        if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= rx_shift_q;
    end

    // Registers, pointers, FSM state and interrupt
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q         <= DIV_WIDTH'(DEFAULT_DIV);
            ctrl_q        <= '0;
            rx_overrun_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            tx_overflow_q <= 1'b0;
            tx_wptr_q     <= '0;
            tx_rptr_q     <= '0;
            rx_wptr_q     <= '0;
            rx_rptr_q     <= '0;
            tx_state_q    <= TxIdle;
            tx_cnt_q      <= '0;
            tx_div_q      <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_par_en_q   <= 1'b0;
            tx_par_q      <= 1'b0;
            rx_state_q    <= RxIdle;
            rx_cnt_q      <= '0;
            rx_div_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_par_en_q   <= 1'b0;
            rx_par_odd_q  <= 1'b0;
            rx_bad_q      <= 1'b0;
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_prev_q     <= 1'b1;
            irq           <= 1'b0;
        end else begin
            if (div_wr)  div_q  <= wdata[DIV_WIDTH-1:0];
            if (ctrl_wr) ctrl_q <= wdata[5:0];
            if (status_wr) begin
                if (wdata[4]) rx_overrun_q  <= 1'b0;
                if (wdata[5]) frame_err_q   <= 1'b0;
                if (wdata[6]) parity_err_q  <= 1'b0;
                if (wdata[7]) tx_overflow_q <= 1'b0;
            end
            // Hardware set wins over a simultaneous clear
            if (set_overrun)    rx_overrun_q  <= 1'b1;
            if (set_frame_err)  frame_err_q   <= 1'b1;
            if (set_parity_err) parity_err_q  <= 1'b1;
            if (data_wr && !tx_push) tx_overflow_q <= 1'b1;
            if (tx_push) tx_wptr_q <= tx_wptr_q + PtrOne;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrOne;
            if (rx_push) rx_wptr_q <= rx_wptr_q + PtrOne;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrOne;
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_div_q      <= tx_div_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_en_q   <= tx_par_en_d;
            tx_par_q      <= tx_par_d;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_div_q      <= rx_div_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_par_en_q   <= rx_par_en_d;
            rx_par_odd_q  <= rx_par_odd_d;
            rx_bad_q      <= rx_bad_d;
            rx_meta_q     <= rx;
            rx_sync_q     <= rx_meta_q;
            rx_prev_q     <= rx_sync_q;
            irq           <= (ctrl_q[4] && !rx_empty) ||
                             (ctrl_q[5] && tx_empty && (tx_state_q == TxIdle));
        end
    end

    // Combinational register read mux
    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: if (!rx_empty) rdata[DATA_BITS-1:0] = rx_head;
            2'd1: rdata[7:0] = {tx_overflow_q, parity_err_q, frame_err_q, rx_overrun_q,
                                !rx_empty, rx_full, tx_empty, tx_full};
            2'd2: rdata[DIV_WIDTH-1:0] = div_q;
            default: rdata[5:0] = ctrl_q;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Self-checking bench for uart_fifo_mmio: directed steps plus randomized frames
// checked against a bit-level frame model and a byte queue.
module tb_uart_fifo_mmio;
    logic        clock = 1'b0;
    logic        reset, we, re, rx;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata;
    logic        tx, irq;

    always #5 clock = ~clock;

    uart_fifo_mmio #(
        .DATA_BITS(8), .FIFO_DEPTH(8), .DIV_WIDTH(16), .DEFAULT_DIV(867)
    ) dut (
        .clock(clock), .reset(reset), .we(we), .re(re), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rx(rx), .tx(tx), .irq(irq)
    );

    int checks = 0;
    int errors = 0;
    bit exp_samples[$];      // expected tx level per clock
    logic [7:0] rxq[$];      // expected RX FIFO contents
    bit m_ovr, m_fe, m_pe;   // expected sticky flags

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] v);
        @(negedge clock);
        addr = a; wdata = v; we = 1'b1;
        @(negedge clock);
        we = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] v);
        @(negedge clock);
        addr = a; re = 1'b1;
        #1 v = rdata;
        @(posedge clock);
        #1 re = 1'b0;
    endtask

    // Frame as seen on the wire: start, 8 data LSB first, optional parity, stop
    task automatic push_frame(input logic [7:0] d, input bit pe, input bit po, input int dv);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ po);
        bits.push_back(1'b1);
        foreach (bits[j]) repeat (dv + 1) exp_samples.push_back(bits[j]);
    endtask

    // Wait (bounded) for the start bit, then compare tx every clock against exp_samples
    task automatic capture_tx(output int mism);
        int w = 0;
        while (tx === 1'b1 && w < 200) begin
            @(negedge clock);
            w++;
        end
        check("tx_start_seen", tx, 0);
        mism = 0;
        foreach (exp_samples[k]) begin
            if (tx !== exp_samples[k]) mism++;
            @(negedge clock);
        end
    endtask

    task automatic drive_rx(input logic [7:0] d, input bit pe, input bit pbit, input bit sbit,
                            input int dv);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(pbit);
        bits.push_back(sbit);
        @(negedge clock);
        foreach (bits[j]) begin
            rx = bits[j];
            repeat (dv + 1) @(negedge clock);
        end
        rx = 1'b1;
        repeat (2 * (dv + 1) + 8) @(negedge clock);
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'h02;  // TX side idle and empty in every RX step
        if (rxq.size() == 8) s |= 32'h04;
        if (rxq.size() > 0)  s |= 32'h08;
        if (m_ovr) s |= 32'h10;
        if (m_fe)  s |= 32'h20;
        if (m_pe)  s |= 32'h40;
        return s;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int mism, dv, kind, w;
        bit pe, po, gp;

        we = 0; re = 0; addr = 0; wdata = 0; rx = 1; reset = 1;
        repeat (3) @(negedge clock);
        check("reset_tx", tx, 1);
        check("reset_irq", irq, 0);
        reset = 0;
        reg_read(2'd2, d); check("reset_div", d, 867);
        reg_read(2'd3, d); check("reset_ctrl", d, 0);
        reg_read(2'd1, d); check("reset_status", d, 32'h02);

        // 0xA5 at DIV=3, no parity
        reg_write(2'd2, 3);
        reg_write(2'd3, 32'h01);
        exp_samples.delete();
        push_frame(8'hA5, 0, 0, 3);
        reg_write(2'd0, 32'hA5);
        capture_tx(mism);
        check("tx_a5_frame", mism, 0);
        check("tx_idle_after_a5", tx, 1);
        reg_read(2'd1, d); check("tx_empty_after_a5", d, 32'h02);

        // Random back-to-back bursts with random divisor and parity
        for (int r = 0; r < 3; r++) begin
            reg_write(2'd3, 0);
            dv = $urandom_range(1, 4);
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            reg_write(2'd2, dv);
            exp_samples.delete();
            for (int i = 0; i < 3; i++) begin
                b = 8'($urandom_range(0, 255));
                push_frame(b, pe, po, dv);
                reg_write(2'd0, {24'd0, b});
            end
            reg_write(2'd3, {28'd0, po, pe, 2'b01});
            capture_tx(mism);
            check("tx_burst", mism, 0);
            reg_read(2'd1, d); check("tx_burst_status", d, 32'h02);
        end

        // TX overflow, then reset during data bit 3
        reg_write(2'd3, 0);
        reg_write(2'd2, 3);
        for (int i = 0; i < 9; i++) reg_write(2'd0, 32'h10 + i);
        reg_read(2'd1, d); check("tx_overflow_status", d, 32'h81);
        reg_write(2'd1, 32'h80);
        reg_read(2'd1, d); check("tx_overflow_w1c", d, 32'h01);
        reg_write(2'd3, 32'h21);
        w = 0;
        while (tx === 1'b1 && w < 50) begin @(negedge clock); w++; end
        check("tx_busy_seen", tx, 0);
        repeat (17) @(negedge clock);
        reset = 1;
        @(negedge clock);
        check("midframe_reset_tx", tx, 1);
        check("midframe_reset_irq", irq, 0);
        reg_read(2'd2, d); check("midframe_reset_div", d, 867);
        reg_read(2'd1, d); check("midframe_reset_status", d, 32'h02);
        reset = 0;

        // RX 0x3C, even parity, good then bad parity bit
        reg_write(2'd2, 3);
        reg_write(2'd3, 32'h07);
        drive_rx(8'h3C, 1, 0, 1, 3);
        reg_read(2'd1, d); check("rx_3c_status", d, 32'h0A);
        reg_read(2'd0, d); check("rx_3c_data", d, 32'h3C);
        reg_read(2'd1, d); check("rx_3c_popped", d, 32'h02);
        drive_rx(8'h3C, 1, 1, 1, 3);
        reg_read(2'd1, d); check("rx_parity_err", d, 32'h42);
        reg_write(2'd1, 32'h40);
        reg_read(2'd1, d); check("rx_parity_w1c", d, 32'h02);

        // Randomized RX frames: good, bad parity, bad stop
        rxq.delete(); m_ovr = 0; m_fe = 0; m_pe = 0;
        for (int i = 0; i < 8; i++) begin
            dv   = $urandom_range(2, 6);
            pe   = 1'($urandom_range(0, 1));
            po   = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 2);
            if (kind == 1 && !pe) kind = 0;
            b  = 8'($urandom_range(0, 255));
            gp = (^b) ^ po;
            reg_write(2'd2, dv);
            reg_write(2'd3, {28'd0, po, pe, 2'b10});
            drive_rx(b, pe, (kind == 1) ? !gp : gp, kind != 2, dv);
            if (kind == 2) m_fe = 1;
            else if (kind == 1) m_pe = 1;
            else if (rxq.size() < 8) rxq.push_back(b);
            else m_ovr = 1;
            reg_read(2'd1, d); check("rx_rand_status", d, model_status());
        end
        while (rxq.size() > 0) begin
            reg_read(2'd0, d); check("rx_rand_data", d, {24'd0, rxq.pop_front()});
        end
        reg_read(2'd0, d); check("rx_empty_read", d, 0);
        reg_write(2'd1, 32'hF0);
        m_ovr = 0; m_fe = 0; m_pe = 0;
        reg_read(2'd1, d); check("rx_rand_cleared", d, model_status());

        // Nine bytes without reads into an 8-deep FIFO
        reg_write(2'd2, 3);
        reg_write(2'd3, 32'h02);
        for (int v = 1; v <= 9; v++) drive_rx(8'(v), 0, 0, 1, 3);
        reg_read(2'd1, d); check("rx_overrun_status", d, 32'h1E);
        for (int v = 1; v <= 8; v++) begin
            reg_read(2'd0, d); check("rx_overrun_data", d, v);
        end
        reg_read(2'd1, d); check("rx_overrun_drained", d, 32'h12);
        reg_write(2'd1, 32'h10);

        // One-clock glitch at DIV=7, then a real frame
        reg_write(2'd2, 7);
        @(negedge clock) rx = 0;
        @(negedge clock) rx = 1;
        repeat (30) @(negedge clock);
        reg_read(2'd1, d); check("rx_glitch_status", d, 32'h02);
        drive_rx(8'h5A, 0, 0, 1, 7);
        reg_read(2'd0, d); check("rx_after_glitch", d, 32'h5A);

        // Interrupts
        reg_write(2'd2, 3);
        reg_write(2'd3, 32'h12);
        @(negedge clock);
        check("irq_rx_idle", irq, 0);
        drive_rx(8'h77, 0, 0, 1, 3);
        check("irq_rx_set", irq, 1);
        reg_read(2'd0, d); check("irq_rx_data", d, 32'h77);
        @(negedge clock);
        @(negedge clock);
        check("irq_rx_clear", irq, 0);
        reg_write(2'd3, 32'h20);
        @(negedge clock);
        check("irq_txe_set", irq, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
